// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared widths and arithmetic helpers for the full adder slice
package full_adder_pkg;

    localparam int POP_W = 2;

    typedef logic [POP_W-1:0] pop_t;

    function automatic pop_t popcount3(input logic a, input logic b, input logic c);
        return pop_t'({1'b0, a}) + pop_t'({1'b0, b}) + pop_t'({1'b0, c});
    endfunction

    // Arithmetic weight of a {carry, sum} result pair: 2*carry + sum.
    function automatic pop_t weigh(input logic s, input logic co);
        return {co, s};
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle between the adder cell and its registered stage
interface full_adder_if;

    logic a;
    logic b;
    logic c;
    logic in_valid;
    logic sum;
    logic carry;
    logic sum_q;
    logic carry_q;
    logic out_valid;
    logic chk_err;

    modport master (
        output a, b, c, in_valid,
        input  sum, carry, sum_q, carry_q, out_valid, chk_err
    );

    modport slave (
        input  a, b, c, in_valid, sum, carry,
        output sum_q, carry_q, out_valid, chk_err
    );

endinterface

// File: rtl/full_adder_half_adder.sv
// rtl/full_adder_half_adder.sv - one-bit half adder building block
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - valid-qualified result register with sticky arithmetic consistency check
module full_adder_reg
    import full_adder_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    full_adder_if.slave   bus
);

    logic sum_r;
    logic carry_r;
    logic valid_r;
    logic err_r;
    pop_t pop_r;

    // The input popcount travels with the result so the check is independent of the adder gates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r   <= 1'b0;
            carry_r <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            pop_r   <= '0;
        end else begin
            if (bus.in_valid) begin
                sum_r   <= bus.sum;
                carry_r <= bus.carry;
                pop_r   <= popcount3(bus.a, bus.b, bus.c);
            end
            valid_r <= bus.in_valid;
            if (valid_r && (weigh(sum_r, carry_r) != pop_r)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.sum_q     = sum_r;
    assign bus.carry_q   = carry_r;
    assign bus.out_valid = valid_r;
    assign bus.chk_err   = err_r;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder with optional registered, self-checked output stage
module full_adder #(
    parameter bit REG_OUT = 1'b1
) (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry,
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic sum_q,
    output logic carry_q,
    output logic out_valid,
    output logic chk_err
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (c),
        .sum   (sum),
        .carry (c1)
    );

    assign carry = c0 | c1;

    generate
        if (REG_OUT) begin : g_reg
            full_adder_if u_bus ();

            assign u_bus.a        = a;
            assign u_bus.b        = b;
            assign u_bus.c        = c;
            assign u_bus.in_valid = in_valid;
            assign u_bus.sum      = sum;
            assign u_bus.carry    = carry;

            full_adder_reg u_reg (
                .clk   (clk),
                .reset (reset),
                .bus   (u_bus.slave)
            );

            assign sum_q     = u_bus.sum_q;
            assign carry_q   = u_bus.carry_q;
            assign out_valid = u_bus.out_valid;
            assign chk_err   = u_bus.chk_err;
        end else begin : g_noreg
            assign sum_q     = 1'b0;
            assign carry_q   = 1'b0;
            assign out_valid = 1'b0;
            assign chk_err   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - table-driven self-checking bench for full_adder
module tb_full_adder;

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       co;
    } vec_t;

    logic clk;
    logic reset;
    bit   clk_en;
    int   checks;
    int   errors;
    vec_t tbl [8];

    full_adder_if bus ();

    full_adder dut (
        .a         (bus.a),
        .b         (bus.b),
        .c         (bus.c),
        .sum       (bus.sum),
        .carry     (bus.carry),
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .sum_q     (bus.sum_q),
        .carry_q   (bus.carry_q),
        .out_valid (bus.out_valid),
        .chk_err   (bus.chk_err)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] abc);
        bus.in_valid = v;
        bus.a        = abc[2];
        bus.b        = abc[1];
        bus.c        = abc[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input logic v, input logic s, input logic co, input logic e);
        chk({name, ".out_valid"}, bus.out_valid, v);
        chk({name, ".sum_q"}, bus.sum_q, s);
        chk({name, ".carry_q"}, bus.carry_q, co);
        chk({name, ".chk_err"}, bus.chk_err, e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        reset  = 1'b1;

        tbl[0] = '{3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 1'b1, 1'b0};
        tbl[2] = '{3'b010, 1'b1, 1'b0};
        tbl[3] = '{3'b011, 1'b0, 1'b1};
        tbl[4] = '{3'b100, 1'b1, 1'b0};
        tbl[5] = '{3'b101, 1'b0, 1'b1};
        tbl[6] = '{3'b110, 1'b0, 1'b1};
        tbl[7] = '{3'b111, 1'b1, 1'b1};

        // combinational sweep with the clock idle
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, tbl[i].abc);
            #10;
            chk($sformatf("comb[%0d].sum", i), bus.sum, tbl[i].s);
            chk($sformatf("comb[%0d].carry", i), bus.carry, tbl[i].co);
        end

        // reset beats in_valid
        clk_en = 1'b1;
        reset  = 1'b1;
        drive(1'b1, 3'b111);
        tick();
        chk_reg("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_reg("reset2", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // back-to-back pipeline 000..111
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].abc);
            tick();
            chk_reg($sformatf("pipe[%0d]", i), 1'b1, tbl[i].s, tbl[i].co, 1'b0);
        end

        // gap: result holds, valid drops
        drive(1'b1, 3'b100);
        tick();
        chk_reg("gap.cap", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b111);
        tick();
        chk_reg("gap.idle1", 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_reg("gap.idle2", 1'b0, 1'b1, 1'b0, 1'b0);

        // mid-stream reset while streaming 110
        drive(1'b1, 3'b110);
        tick();
        chk_reg("mid.pre", 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 3'b111);
        tick();
        chk_reg("mid.pre2", 1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 3'b110);
        tick();
        chk_reg("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 3'b111);
        tick();
        chk_reg("mid.resume", 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 3'b011);
        tick();
        chk_reg("mid.resume2", 1'b1, 1'b0, 1'b1, 1'b0);

        // checker: corrupt the captured sum while out_valid is high
        drive(1'b1, 3'b100);
        tick();
        chk_reg("chk.cap", 1'b1, 1'b1, 1'b0, 1'b0);
        force dut.g_reg.u_reg.sum_r = 1'b0;
        drive(1'b0, 3'b000);
        tick();
        chk("chk.flag", bus.chk_err, 1'b1);
        release dut.g_reg.u_reg.sum_r;
        drive(1'b1, 3'b101);
        tick();
        chk_reg("chk.sticky1", 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'b000);
        tick();
        chk_reg("chk.sticky2", 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        chk_reg("chk.clear", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 3'b010);
        tick();
        chk_reg("chk.after", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 3'b000);
        tick();
        chk_reg("chk.after2", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
